// File: rtl/mdu_sched_pkg.sv
// Shared MDU definitions: op codes driven by the decoder and the scheduler
// state encodings, which the stall control also reads.
package mdu_sched_pkg;

  localparam int MDU_OP_W  = 4;
  localparam int MDU_CNT_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_RUN  = 1'b1
  } mds_state_e;

endpackage

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter that times a multi-cycle MDU operation.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low clear
//   load_i     : load load_val_i (takes priority over counting)
//   load_val_i : number of busy cycles to time
//   en_i       : decrement while the operation is in flight
//   done_o     : count==1, i.e. the current cycle is the last busy cycle
module mdu_lat_counter
  import mdu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [MDU_CNT_W-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 done_o
);

  logic [MDU_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == MDU_CNT_W'(1));

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler for the E stage. Owns HI/LO, times each
// multiply/divide with a latency counter and reports busy to stall control.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low; clears all state
//   start  : issue strobe for op
//   op     : MDU op code (mdu_op_e)
//   rs, rt : forwarded operands
//   cancel : same-cycle exception request; blocks the issue
//   busy   : high while a multiply/divide is in flight
//   md_out : HI for MFHI, LO for MFLO, else 0
//   hi, lo : architectural HI/LO
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         rs,
  input  logic [31:0]         rt,
  input  logic                cancel,
  output logic                busy,
  output logic [31:0]         md_out,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  // Returns {remainder, quotient}; SV signed division truncates toward zero
  // and the remainder follows the dividend's sign.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  function automatic logic [63:0] mdu_result(input logic [MDU_OP_W-1:0] o,
                                             input logic [31:0] a, input logic [31:0] b);
    case (o)
      MDU_MULT:  return mul_s(a, b);
      MDU_MULTU: return mul_u(a, b);
      MDU_DIV:   return div_s(a, b);
      MDU_DIVU:  return div_u(a, b);
      default:   return 64'd0;
    endcase
  endfunction

  mds_state_e           state_q, state_d;
  logic [31:0]          hi_q, hi_d, lo_q, lo_d;
  logic [31:0]          opa_q, opa_d, opb_q, opb_d;
  logic [MDU_OP_W-1:0]  pop_q, pop_d;
  logic                 accept;
  logic                 pend_is_div;
  logic                 cnt_load, cnt_done;
  logic [MDU_CNT_W-1:0] cnt_val;

  assign accept      = start && !cancel && (state_q == MDS_IDLE);
  assign pend_is_div = (pop_q == MDU_DIV) || (pop_q == MDU_DIVU);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    pop_d    = pop_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      MDS_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = MDS_RUN;
              opa_d    = rs;
              opb_d    = rt;
              pop_d    = op;
              cnt_load = 1'b1;
              cnt_val  = ((op == MDU_DIV) || (op == MDU_DIVU)) ?
                         MDU_CNT_W'(DIV_LAT) : MDU_CNT_W'(MUL_LAT);
            end
            MDU_MTHI: hi_d = rs;
            MDU_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      MDS_RUN: begin
        if (cnt_done) begin
          state_d = MDS_IDLE;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (!(pend_is_div && (opb_q == 32'd0))) begin
            {hi_d, lo_d} = mdu_result(pop_q, opa_q, opb_q);
          end
        end
      end
      default: state_d = MDS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDS_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      pop_q   <= MDU_NONE;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      pop_q   <= pop_d;
    end
  end

  mdu_lat_counter u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (state_q == MDS_RUN),
    .done_o     (cnt_done)
  );

  assign busy   = (state_q == MDS_RUN);
  assign hi     = hi_q;
  assign lo     = lo_q;
  // No bypass of the pending result: stall logic keeps MFHI/MFLO out of RUN.
  assign md_out = (op == MDU_MFHI) ? hi_q :
                  (op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = MDU_NONE;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] md_out, hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .md_out(md_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present one op for one clock edge, then return 1ns after that edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    op = o; rs = a; rt = b; cancel = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE; cancel = 1'b0;
  endtask

  // Count busy cycles until idle, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %h exp 0", busy); end
  endtask

  task automatic test_mult;
    int n;
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_latency got %0d exp 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
    op = MDU_MFHI; #1;
    checks++; if (md_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi_md_out got %h exp ffffffff", md_out); end
    op = MDU_NONE; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL none_md_out got %h exp 0", md_out); end
  endtask

  task automatic test_div;
    int n;
    @(posedge clk); #1;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_latency got %0d exp 10", n); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 2", hi); end
    // back-to-back: issue in the first idle cycle
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_latency got %0d exp 10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
  endtask

  task automatic test_div_zero;
    int n;
    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0);
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mthi got %h exp 11", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h exp 0", busy); end
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b0);
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mtlo got %h exp 22", lo); end
    issue(MDU_DIV, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div0_latency got %0d exp 10", n); end
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL div0_hi got %h exp 11", hi); end
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL div0_lo got %h exp 22", lo); end
  endtask

  task automatic test_cancel;
    int n;
    issue(MDU_MULTU, 32'h80000000, 32'd2, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %h exp 0", busy); end
    @(posedge clk); #1;
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL cancel_hilo got %h_%h exp 11_22", hi, lo); end
    issue(MDU_MULTU, 32'h80000000, 32'd2, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cancel = (n == 3);
      if (n == 1) begin
        op = MDU_MFLO; #1;
        checks++; if (md_out !== 32'h22) begin errors++; $display("FAIL mflo_in_run got %h exp 22", md_out); end
        op = MDU_NONE;
      end
      @(posedge clk); #1;
    end
    cancel = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_latency got %0d exp 5", n); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL multu_hi got %h exp 1", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL multu_lo got %h exp 0", lo); end
  endtask

  task automatic test_mtlo;
    issue(MDU_MTLO, 32'hDEADBEEF, 32'd0, 1'b1);
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mtlo_cancel got %h exp 0", lo); end
    issue(MDU_MTLO, 32'hDEADBEEF, 32'd0, 1'b0);
    checks++; if (lo !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_write got %h exp deadbeef", lo); end
    op = MDU_MFLO; #1;
    checks++; if (md_out !== 32'hDEADBEEF) begin errors++; $display("FAIL mflo_md_out got %h exp deadbeef", md_out); end
    op = MDU_NONE;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run2_busy got %h exp 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %h exp 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo got %h_%h exp 0_0", hi, lo); end
    @(posedge clk); #1; reset = 1'b1;
    issue(MDU_MTHI, 32'd1, 32'd0, 1'b0);
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL post_rst_mthi got %h exp 1", hi); end
    repeat (6) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL post_rst_stale got busy=%h hi=%h lo=%h exp 0/1/0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_cancel();
    test_mtlo();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stall logic must never let an issue reach the scheduler while busy.
  always @(negedge clk) begin
    if (reset && busy && start) begin
      errors++;
      $display("FAIL start_while_busy got start=1 exp 0");
    end
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler for the E stage; the pipeline's single MDU resource.
- Accepts one MDU operation per issue and owns the HI/LO architectural registers.
- Runs a latency counter and drives busy to the hazard/stall logic.
- Applies exception-request cancellation so no MDU side effect commits for a flushed instruction.

Parameters:
- MUL_LAT, 5: busy cycles for MULT/MULTU (1..15).
- DIV_LAT, 10: busy cycles for DIV/DIVU (1..15).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- start  in  1  E-stage issue strobe for the operation in op
- op  in  4  MDU op code; values from shared header: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- rs  in  32  forwarded rs operand
- rt  in  32  forwarded rt operand
- cancel  in  1  exception/interrupt request in the same cycle; suppresses the E-stage issue
- busy  out  1  registered; high while a mult/div is in flight
- md_out  out  32  HI for MFHI, LO for MFLO, else 0; combinational from op and registers
- hi  out  32  current HI register
- lo  out  32  current LO register

Behaviour:
- Reset (reset low, async):
  - hi=lo=0, busy=0, count=0
  - pending result cleared
  - state IDLE
- Issue acceptance:
  - accept = start & !cancel & (state==IDLE).
  - start during RUN is ignored; the stall logic guarantees it never occurs; the bench flags it.
- Ops acting on accept:
  - MULT: pending {hi,lo} = signed rs*rt (64-bit).
  - MULTU: pending {hi,lo} = unsigned rs*rt (64-bit).
  - DIV: pending lo = signed rs/rt, hi = signed rs%rt. Quotient truncates toward zero; remainder takes the sign of rs.
  - DIVU: pending lo = unsigned rs/rt, hi = unsigned rs%rt.
  - For MULT/MULTU/DIV/DIVU: latch the operands, load count = MUL_LAT or DIV_LAT, go to RUN.
  - DIV/DIVU with rt==0: enter RUN for DIV_LAT cycles anyway, but HI/LO stay unchanged at completion.
  - MTHI: hi <= rs at the next edge, no busy.
  - MTLO: lo <= rs at the next edge, no busy.
  - MFHI, MFLO, NONE: no state change.
- State machine:
  - IDLE --accept mult/div--> RUN.
  - RUN: count decrements each cycle.
  - RUN with count==1 --> IDLE: commit pending to hi/lo on that edge.
  - busy = (state==RUN).
  - Latency is exactly LAT cycles of busy=1, starting the cycle after the accept edge.
  - New HI/LO is visible on hi/lo/md_out the first cycle busy=0.
- Cancel:
  - Gates only the same-cycle issue: no RUN, and MTHI/MTLO do not write.
  - cancel during RUN does not abort; the in-flight op belongs to an older committed instruction and completes normally.
- Back-to-back: a new op may be accepted in the first cycle after RUN→IDLE. No issue in the commit cycle itself, because busy is still 1 there.
- md_out does not bypass pending results. MFHI/MFLO while busy returns the old value; stall logic prevents this case.
- Reset mid-RUN: busy drops immediately; the pending result is discarded; hi/lo return to 0.

Decomposition:
- Shared header: MDU op-code constants (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO) and state encodings (MDS_IDLE, MDS_RUN), reused by the decoder and stall control.
- One sub-module: mdu_lat_counter.
  - Loadable 4-bit down-counter with load, load value and done (count==1) outputs.
  - Async active-low clear.
  - The arithmetic stays in mdu_sched.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3, start=1 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MFHI gives md_out=0xFFFFFFFF.
- DIVU rs=100, rt=7 -> busy 10 cycles; lo=14, hi=2. DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=5, rt=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> busy 10 cycles; hi=0x11 and lo=0x22 unchanged.
- MULTU rs=0x80000000, rt=2 issued with cancel=1 -> busy stays 0, hi/lo unchanged. Same op with cancel=0, then cancel pulsed in RUN cycle 3 -> completes; hi=1, lo=0.
- MTLO rs=0xDEADBEEF with cancel=1 -> lo unchanged. Same without cancel -> lo=0xDEADBEEF next cycle; MFLO md_out=0xDEADBEEF.
- MULT issued, reset driven low in RUN cycle 2 (async, mid-clock) -> busy=0, hi=lo=0 immediately. After release, MTHI rs=1 is accepted the next cycle.
